mult8x8_datapath: RTL
=====================

Name: mult8x8_datapath

Overview:
- Arithmetic datapath for the sequential 8x8 shift-add multiplier. It sits directly downstream of the multiplier controller.
- It consumes the controller's input_sela, input_selb, shift_sel and done signals. It forms one 4x4 partial product per step, shifts it, and accumulates it into a 16-bit result.
- It publishes the final product and flags for protocol errors.

Parameters:
- WIDTH, 8: operand width. Must be even; NIB = WIDTH/2 is derived and not user-settable.
- STEPS, 4: number of accumulate steps expected between st and done.

Ports:
- clk  input  1  system clock, rising edge.
- rst  input  1  asynchronous, active-low reset.
- st  input  1  start. Captures dataa/datab, clears the accumulator and step count, sets busy.
- dataa  input  WIDTH  multiplicand, sampled only when st=1.
- datab  input  WIDTH  multiplier, sampled only when st=1.
- input_sela  input  1  nibble select for A: 0 selects A[NIB-1:0], 1 selects A[WIDTH-1:NIB].
- input_selb  input  1  nibble select for B, same encoding as input_sela.
- shift_sel  input  2  partial-product shift: 00 is <<0, 01 is <<NIB, 10 is <<WIDTH, 11 is reserved.
- step_vld  input  1  accumulate one partial product this cycle.
- done  input  1  controller end-of-sequence strobe.
- product  output  2*WIDTH  registered result.
- prod_valid  output  1  product holds a finished result.
- busy  output  1  sequence in progress.
- seq_err  output  1  the last sequence was malformed.

Behaviour:
- Reset (rst=0, async): product=0, prod_valid=0, busy=0, seq_err=0; internal accumulator, step count and operand registers all 0. Reset asserted mid-sequence aborts it with no result.
- States: IDLE (busy=0) and RUN (busy=1). busy is a registered output.
- IDLE to RUN: on a clk edge with st=1.
  - Operands are captured on that edge; acc=0 and step_cnt=0.
  - prod_valid and seq_err clear on the same edge.
- st=1 while in RUN: restarts (same actions as above). Any step_vld or done in that cycle is ignored.
- Step in RUN, st=0, step_vld=1:
  - pp = a_nib * b_nib, unsigned, 2*NIB bits.
  - pp is zero-extended to 2*WIDTH bits and shifted per shift_sel; acc <= acc + shifted pp, modulo 2^(2*WIDTH).
  - step_cnt increments and saturates at 7.
  - Latency: acc reflects a step one cycle after the step_vld edge.
- shift_sel=11 with step_vld=1: a shift of 0 is used and the seq_err sticky bit is set.
- Finish in RUN, st=0, done=1:
  - product <= acc + (step_vld ? shifted pp : 0), so a final step and done in the same cycle both count.
  - prod_valid <= 1 and the block returns to IDLE.
  - seq_err is set if the final step count ≠ STEPS.
- prod_valid and product hold until the next st or reset.
- step_vld or done in IDLE: ignored, no state change.
- No overflow is possible for a legal sequence: the maximum value is (2^WIDTH-1)^2.

Decomposition:
- Shared package/header mult_defs: WIDTH/NIB constants, SHIFT_0/SHIFT_NIB/SHIFT_FULL/SHIFT_RSVD encodings, IDLE/RUN state encodings.
- One sub-module, mult4x4: purely combinational NIB x NIB unsigned multiplier, instantiated once.
- Nibble muxes, shifter, accumulator and state logic stay in the top module.

Test Plan:
- Reset with rst=0 mid-RUN -> immediately product=0, prod_valid=0, busy=0, seq_err=0.
- 0xAB * 0xCD, four steps: (sela,selb,shift) = (0,0,00), (0,1,01), (1,0,01), (1,1,10); then done -> product=0x88EF, prod_valid=1, seq_err=0, busy=0 the cycle after done.
- 0xFF * 0xFF, with the 4th step_vld in the same cycle as done -> product=0xFE01, seq_err=0.
- 0x00 * 0x5A, legal sequence -> product=0x0000, prod_valid=1; then step_vld/done pulses in IDLE -> product unchanged.
- Only 3 steps then done -> seq_err=1, prod_valid=1. Separately, a run containing shift_sel=11 -> seq_err=1.
- st mid-RUN with new operands 0x12 * 0x34, then a full sequence -> product=0x03A8 with no contribution from the aborted run.

Source files
------------

// File: rtl/mult_defs.sv
// Shared constants for the 8x8 shift-add multiplier datapath: operand width,
// partial-product shift encodings and the datapath state encoding.
package mult_defs;

    localparam int WIDTH = 8;
    localparam int NIB   = WIDTH / 2;
    localparam int STEPS = 4;

    localparam logic [1:0] SHIFT_0    = 2'b00;
    localparam logic [1:0] SHIFT_NIB  = 2'b01;
    localparam logic [1:0] SHIFT_FULL = 2'b10;
    localparam logic [1:0] SHIFT_RSVD = 2'b11;

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

endpackage

// File: rtl/mult4x4.sv
// Purely combinational NIB x NIB unsigned multiplier producing a 2*NIB-bit
// partial product.
module mult4x4 #(
    parameter int NIB = 4
) (
    input  logic [NIB-1:0]   a,
    input  logic [NIB-1:0]   b,
    output logic [2*NIB-1:0] p
);

    assign p = {{NIB{1'b0}}, a} * {{NIB{1'b0}}, b};

endmodule

// File: rtl/mult8x8_datapath.sv
// Shift-add multiplier datapath: selects operand nibbles, forms and shifts one
// partial product per step, accumulates it and publishes the final product.
module mult8x8_datapath
    import mult_defs::*;
#(
    parameter int WIDTH = mult_defs::WIDTH,
    parameter int STEPS = mult_defs::STEPS
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               st,
    input  logic [WIDTH-1:0]   dataa,
    input  logic [WIDTH-1:0]   datab,
    input  logic               input_sela,
    input  logic               input_selb,
    input  logic [1:0]         shift_sel,
    input  logic               step_vld,
    input  logic               done,
    output logic [2*WIDTH-1:0] product,
    output logic               prod_valid,
    output logic               busy,
    output logic               seq_err
);

    localparam int HALF = WIDTH / 2;
    localparam logic [2:0] CNT_MAX  = 3'd7;
    localparam logic [2:0] CNT_GOAL = 3'(STEPS);

    state_t             state_r, state_next_s;
    logic [WIDTH-1:0]   a_r, b_r;
    logic [2*WIDTH-1:0] acc_r;
    logic [2:0]         cnt_r;

    logic [HALF-1:0]    a_nib_s, b_nib_s;
    logic [2*HALF-1:0]  pp_s;
    logic [2*WIDTH-1:0] pp_ext_s, shifted_s, add_s, sum_s;
    logic [2:0]         cnt_next_s;
    logic               rsvd_step_s, cnt_bad_s;

    mult4x4 #(.NIB(HALF)) u_mult4x4 (
        .a (a_nib_s),
        .b (b_nib_s),
        .p (pp_s)
    );

    // Nibble selection, partial-product shift and accumulator sum.
    always_comb begin
        a_nib_s   = input_sela ? a_r[WIDTH-1:HALF] : a_r[HALF-1:0];
        b_nib_s   = input_selb ? b_r[WIDTH-1:HALF] : b_r[HALF-1:0];
        pp_ext_s  = {{(2*WIDTH-2*HALF){1'b0}}, pp_s};
        shifted_s = pp_ext_s;
        case (shift_sel)
            SHIFT_0:    shifted_s = pp_ext_s;
            SHIFT_NIB:  shifted_s = pp_ext_s << HALF;
            SHIFT_FULL: shifted_s = pp_ext_s << WIDTH;
            default:    shifted_s = pp_ext_s;
        endcase
        if (step_vld) begin
            add_s = shifted_s;
        end else begin
            add_s = {(2*WIDTH){1'b0}};
        end
        sum_s = acc_r + add_s;
        rsvd_step_s = step_vld && (shift_sel == SHIFT_RSVD);
    end

    // Saturating step count including any step landing in this cycle.
    always_comb begin
        cnt_next_s = cnt_r;
        if (step_vld && (cnt_r != CNT_MAX)) begin
            cnt_next_s = cnt_r + 3'd1;
        end else begin
            cnt_next_s = cnt_r;
        end
        cnt_bad_s = (cnt_next_s != CNT_GOAL);
    end

    // Next-state logic; st always (re)starts a sequence.
    always_comb begin
        state_next_s = state_r;
        case (state_r)
            IDLE: begin
                if (st) state_next_s = RUN;
                else    state_next_s = IDLE;
            end
            RUN: begin
                if (st)        state_next_s = RUN;
                else if (done) state_next_s = IDLE;
                else           state_next_s = RUN;
            end
            default: state_next_s = IDLE;
        endcase
    end

    // State register.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state_r <= IDLE;
        else      state_r <= state_next_s;
    end

    // Operand capture, accumulation, result publication and error flag.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            a_r        <= {WIDTH{1'b0}};
            b_r        <= {WIDTH{1'b0}};
            acc_r      <= {(2*WIDTH){1'b0}};
            cnt_r      <= 3'd0;
            product    <= {(2*WIDTH){1'b0}};
            prod_valid <= 1'b0;
            seq_err    <= 1'b0;
        end else if (st) begin
            a_r        <= dataa;
            b_r        <= datab;
            acc_r      <= {(2*WIDTH){1'b0}};
            cnt_r      <= 3'd0;
            prod_valid <= 1'b0;
            seq_err    <= 1'b0;
        end else if (state_r == RUN) begin
            acc_r <= sum_s;
            cnt_r <= cnt_next_s;
            if (done) begin
                product    <= sum_s;
                prod_valid <= 1'b1;
                seq_err    <= seq_err | rsvd_step_s | cnt_bad_s;
            end else begin
                seq_err    <= seq_err | rsvd_step_s;
            end
        end
    end

    assign busy = (state_r == RUN);

endmodule
